// File: rtl/bd_pkg.sv
// Shared types and defaults for the bit-decoder frame receiver.
// Holds the FSM state set, error codes and the default sync marker.
package bd_pkg;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CHK,
    DRAIN
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_LEN,
    ERR_CHK,
    ERR_TIMEOUT
  } err_code_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Address width for a buffer of the given depth; never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/bd_frame_buf.sv
// Payload buffer: single write port, registered read port updated only on re.
// rdata holds its value between reads so a stalled consumer sees a stable byte.
module bd_frame_buf
  import bd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];
  logic [7:0] rdata_q, rdata_d;

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  // Storage needs no reset; only the visible read register is cleared.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= 8'h00;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bd_frame_rx.sv
// Frame receiver: hunts sync, buffers length/payload/XOR checksum, replays good payloads.
// First out byte one cycle after the checksum strobe; bytes arriving while draining are dropped.
module bd_frame_rx
  import bd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int         MAX_LEN   = 16,
  parameter int         TIMEOUT   = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [7:0] drop_cnt
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = addr_w(MAX_LEN);
  localparam int IW = $clog2(TIMEOUT);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [IW-1:0] IDLE_LIM  = IW'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [7:0]  chk_q, chk_d;
  logic [IW-1:0] idle_q, idle_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic        frame_ok_q, frame_ok_d;
  logic        frame_err_q, frame_err_d;
  err_code_t   err_code_q, err_code_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  logic          buf_we, buf_re;
  logic [AW-1:0] buf_waddr, buf_raddr;
  logic [7:0]    buf_rdata;

  logic          len_bad, chk_match, idle_hit, is_last, handshake;
  logic [LW-1:0] idx_inc;

  assign len_bad   = (in_data == 8'h00) || (in_data > MAX_LEN_B);
  assign chk_match = (in_data == chk_q);
  assign idle_hit  = (idle_q == IDLE_LIM);
  assign is_last   = (idx_q == len_q - LW'(1));
  assign idx_inc   = idx_q + LW'(1);
  assign handshake = out_valid_q && out_ready;

  bd_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (in_data),
    .re    (buf_re),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= HUNT;
      len_q       <= '0;
      idx_q       <= '0;
      chk_q       <= 8'h00;
      idle_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      drop_cnt_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      chk_q       <= chk_d;
      idle_q      <= idle_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HUNT: begin
        if (in_valid && (in_data == SYNC_BYTE)) state_d = LEN;
      end
      LEN: begin
        if (in_valid)      state_d = len_bad ? HUNT : PAYLOAD;
        else if (idle_hit) state_d = HUNT;
      end
      PAYLOAD: begin
        if (in_valid) begin
          if (is_last) state_d = CHK;
        end else if (idle_hit) begin
          state_d = HUNT;
        end
      end
      CHK: begin
        if (in_valid)      state_d = chk_match ? DRAIN : HUNT;
        else if (idle_hit) state_d = HUNT;
      end
      DRAIN: begin
        // A byte arriving alongside the final handshake is a drop, never a sync candidate.
        if (handshake && is_last) state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    len_d       = len_q;
    idx_d       = idx_q;
    chk_d       = chk_q;
    idle_d      = '0;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    drop_cnt_d  = drop_cnt_q;
    buf_we      = 1'b0;
    buf_waddr   = idx_q[AW-1:0];
    buf_re      = 1'b0;
    buf_raddr   = idx_q[AW-1:0];

    unique case (state_q)
      LEN, PAYLOAD, CHK: begin
        if (!in_valid) begin
          if (idle_hit) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
          end else begin
            idle_d = idle_q + IW'(1);
          end
        end else if (state_q == LEN) begin
          if (len_bad) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
          end else begin
            len_d = in_data[LW-1:0];
            chk_d = in_data;
            idx_d = '0;
          end
        end else if (state_q == PAYLOAD) begin
          buf_we = 1'b1;
          chk_d  = chk_q ^ in_data;
          idx_d  = idx_inc;
        end else begin
          if (chk_match) begin
            frame_ok_d  = 1'b1;
            err_code_d  = ERR_NONE;
            idx_d       = '0;
            buf_re      = 1'b1;
            buf_raddr   = '0;
            out_valid_d = 1'b1;
            out_last_d  = (len_q == LW'(1));
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
          end
        end
      end
      DRAIN: begin
        if (in_valid && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
        if (handshake) begin
          if (is_last) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            idx_d      = idx_inc;
            buf_re     = 1'b1;
            buf_raddr  = idx_inc[AW-1:0];
            out_last_d = (idx_inc == len_q - LW'(1));
          end
        end
      end
      default: ;
    endcase
  end

  assign out_data  = buf_rdata;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_bd_frame_rx.sv
// Directed bench for bd_frame_rx: expected payload bytes are queued as frames are sent
// and popped by a monitor on each output handshake.
module tb_bd_frame_rx;

  typedef logic [7:0] bq_t[$];

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  int exp_ok = 0;
  int exp_err = 0;
  logic [8:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  bd_frame_rx dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Monitor: scoreboard pop on handshake, stall stability, pulse bookkeeping.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (prev_stall) begin
        checks++;
        assert (out_valid === 1'b1 && out_data === prev_data) else begin
          errors++;
          $error("FAIL stall_hold observed=%0h/%0b expected=%0h/1", out_data, out_valid, prev_data);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $error("FAIL unexpected_out observed=%0h expected=none", out_data);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          assert ({out_data, out_last} === e) else begin
            errors++;
            $error("FAIL out_byte observed=%0h/%0b expected=%0h/%0b", out_data, out_last, e[8:1], e[0]);
          end
        end
      end
      checks++;
      assert (!(frame_ok === 1'b1 && frame_err === 1'b1)) else begin
        errors++;
        $error("FAIL ok_err_overlap observed=11 expected=not both");
      end
      if (frame_ok === 1'b1) ok_cnt++;
      if (frame_err === 1'b1) err_cnt++;
      prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic good_frame(input bq_t pl);
    logic [7:0] c;
    c = 8'(pl.size());
    send(8'hA5);
    send(c);
    foreach (pl[i]) begin
      exp_q.push_back({pl[i], (i == pl.size() - 1)});
      c = c ^ pl[i];
      send(pl[i]);
    end
    exp_ok++;
    send(c);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid === 1'b1) && n < 200) begin
      tick();
      n++;
    end
    check(tag, {23'd0, out_valid, exp_q.size() == 0 ? 8'd0 : 8'hFF}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t pl;
    rst       = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("reset_outputs", {out_data, out_valid, out_last, frame_ok, frame_err, err_code, drop_cnt}, 32'd0);
    rst = 1'b1;
    tick();

    // Noise in HUNT is ignored and not counted as drops.
    send(8'h00); send(8'hFF); send(8'h5A);
    check("hunt_no_drop", drop_cnt, 8'd0);

    // Good frame, full throughput.
    pl = '{8'h11, 8'h22, 8'h33};
    good_frame(pl);
    check("good_ok_pulse", frame_ok, 1'b1);
    check("good_first_lat", {out_valid, out_data}, {1'b1, 8'h11});
    check("good_err_code", err_code, 2'd0);
    repeat (3) tick();
    check("good_throughput", {out_valid, exp_q.size() == 0}, 2'b01);
    check("good_no_drop", drop_cnt, 8'd0);

    // Byte arriving with the final handshake is dropped, not taken as sync.
    pl = '{8'h44, 8'h55};
    good_frame(pl);
    tick();
    send(8'hA5);
    check("final_hs_drop", drop_cnt, 8'd1);
    pl = '{8'h66};
    good_frame(pl);
    check("after_drop_ok", frame_ok, 1'b1);
    wait_drain("len1_drain");

    // Backpressure with ready pattern 1,0,0,1.
    pl = '{8'h11, 8'h22, 8'h33};
    good_frame(pl);
    for (int i = 0; i < 16; i++) begin
      out_ready = (i % 4 == 0 || i % 4 == 3);
      tick();
    end
    out_ready = 1'b1;
    wait_drain("bp_drain");

    // Max-length frame with sync-valued payload bytes.
    pl = {};
    for (int i = 0; i < 16; i++) pl.push_back((i % 3 == 0) ? 8'hA5 : 8'(i * 17));
    good_frame(pl);
    wait_drain("max_len_drain");

    // Bad checksum.
    send(8'hA5); send(8'h02); send(8'hAA); send(8'hBB); send(8'h00);
    exp_err++;
    check("bad_chk", {frame_err, frame_ok, out_valid, err_code}, {3'b100, 2'd2});
    // Zero length.
    send(8'hA5); send(8'h00);
    exp_err++;
    check("len_zero", {frame_err, err_code}, {1'b1, 2'd1});
    // Length above maximum.
    send(8'hA5); send(8'h11);
    exp_err++;
    check("len_over", {frame_err, err_code}, {1'b1, 2'd1});
    tick();
    check("err_code_held", {frame_err, err_code}, {1'b0, 2'd1});

    // Timeout after TIMEOUT idle cycles.
    send(8'hA5); send(8'h02); send(8'hAA);
    repeat (1023) tick();
    check("timeout_not_yet", {frame_err, err_code}, {1'b0, 2'd1});
    tick();
    exp_err++;
    check("timeout_fire", {frame_err, err_code}, {1'b1, 2'd3});
    pl = '{8'h5A, 8'hA5, 8'h00, 8'hFF};
    good_frame(pl);
    check("post_timeout_ok", {frame_ok, err_code}, {1'b1, 2'd0});
    wait_drain("post_timeout_drain");

    // Drop counter saturation under held backpressure.
    out_ready = 1'b0;
    pl = '{8'hC1, 8'hC2, 8'hC3};
    good_frame(pl);
    for (int i = 0; i < 300; i++) send(8'hA5);
    check("drop_sat", drop_cnt, 8'd255);
    check("drop_hold_byte", {out_valid, out_data}, {1'b1, 8'hC1});
    out_ready = 1'b1;
    wait_drain("drop_drain");

    // Reset mid-frame aborts silently.
    send(8'hA5); send(8'h03); send(8'h11);
    rst = 1'b0;
    tick();
    check("midreset_outputs", {out_data, out_valid, out_last, frame_ok, frame_err, err_code, drop_cnt}, 32'd0);
    rst = 1'b1;
    tick();
    pl = '{8'h11, 8'h22, 8'h33};
    good_frame(pl);
    check("post_reset_ok", frame_ok, 1'b1);
    wait_drain("post_reset_drain");

    check("ok_count", ok_cnt, exp_ok);
    check("err_count", err_cnt, exp_err);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bd_frame_rx.md
Name: bd_frame_rx

Overview:
Downstream consumer of the bit-decoder byte stream. Hunts for a sync byte, then captures a length byte, payload and XOR checksum into an internal buffer. Validated payloads are replayed on a valid/ready byte stream with a last marker. Bad frames are reported on status outputs and never forwarded.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker.
MAX_LEN, 16, maximum payload bytes (1..255); sets buffer depth.
TIMEOUT, 1024, idle clk cycles allowed between bytes inside a frame.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
in_data  in  8  decoded byte from bit decoder
in_valid  in  1  one-cycle strobe, in_data valid
out_data  out  8  payload byte
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts when out_valid && out_ready
out_last  out  1  high with final payload byte
frame_ok  out  1  one-cycle pulse, checksum matched
frame_err  out  1  one-cycle pulse, frame aborted
err_code  out  2  0 none, 1 bad length, 2 checksum, 3 timeout; held until next frame_ok/frame_err
drop_cnt  out  8  bytes dropped during DRAIN, saturating at 255

Behaviour:
- Reset: rst==0 at posedge. State HUNT. All outputs 0. Counters, index and checksum cleared. Buffer contents don't-care. Reset mid-frame or mid-drain aborts silently with no frame_err.
- HUNT: in_valid && in_data==SYNC_BYTE -> LEN. Other bytes ignored; they are not counted as drops.
- LEN: on byte, if 0 or >MAX_LEN -> frame_err, err_code=1, HUNT. Otherwise store len, chk=in_data, idx=0 -> PAYLOAD.
- PAYLOAD: on each byte, buf[idx]=in_data, chk^=in_data, idx++. When idx reaches len-1 and that byte is accepted -> CHK. Payload bytes equal to SYNC_BYTE are data; there is no resync.
- CHK: on byte, if in_data==chk -> frame_ok pulse in the next cycle, err_code=0, idx=0 -> DRAIN. Otherwise frame_err, err_code=2, HUNT.
- Timeout: in LEN, PAYLOAD and CHK, an idle counter resets on every in_valid and increments otherwise. Reaching TIMEOUT-1 -> frame_err, err_code=3, HUNT. No timeout in HUNT or DRAIN.
- DRAIN: out_valid=1 and out_data=buf[idx] are registered outputs.
  - out_last=1 when idx==len-1.
  - On handshake, idx++. Handshake on the last byte -> HUNT, with out_valid low the next cycle.
  - out_data is held stable while out_valid && !out_ready.
  - Every in_valid during DRAIN increments drop_cnt, saturating. drop_cnt clears only on reset.
- Latency: first out_valid occurs 1 cycle after the CHK byte strobe. Sustained throughput is 1 byte/cycle with out_ready tied high.
- Simultaneous events: frame_ok and frame_err are never high together. An in_valid on the same cycle as the final DRAIN handshake is dropped and counted; it is not treated as a sync candidate.
- Widths:
  - idx and len counters are clog2(MAX_LEN+1) bits.
  - Idle counter is clog2(TIMEOUT) bits.
  - Checksum is 8-bit XOR over the length byte and all payload bytes.

Decomposition:
- Package bd_pkg holds:
  - state enum {HUNT, LEN, PAYLOAD, CHK, DRAIN}
  - err_code enum {ERR_NONE, ERR_LEN, ERR_CHK, ERR_TIMEOUT}
  - default SYNC_BYTE constant
- Single sub-module bd_frame_buf: MAX_LEN x 8 register/RAM buffer with write port (we, waddr, wdata) and registered read port (raddr, rdata). The FSM, checksum and counters stay in the top level.

Test Plan:
- Good frame: A5 03 11 22 33 03 with out_ready=1 -> frame_ok pulse; out bytes 11,22,33 on consecutive cycles; out_last only with 33; err_code=0.
- Backpressure: same frame, out_ready toggling 1,0,0,1,... -> no byte lost or repeated; out_data stable while stalled; byte order unchanged.
- Bad checksum / bad length:
  - A5 02 AA BB 00 -> frame_err, err_code=2, no out_valid.
  - A5 00 -> frame_err, err_code=1.
  - A5 11 (MAX_LEN=16) -> frame_err, err_code=1.
- Timeout: A5 02 AA, then idle TIMEOUT cycles -> frame_err, err_code=3, back in HUNT. A following good frame is decoded correctly.
- Drop count: good frame with out_ready=0 held, then 300 in_valid strobes -> drop_cnt=255 (saturated). Release out_ready -> full payload delivered intact.
- Reset mid-frame: A5 03 11, then rst low for 1 cycle -> all outputs 0, no frame_err. A following good frame decodes normally.
